uart_rx_8n1: RTL

- UART receiver for 8N1 frames: 1 start bit, 8 data bits LSB first, 1 stop bit, no parity.
- Downstream counterpart of uart_tx_8n1; consumes the serial line that the transmitter's uart_tx drives.
- Runs on an oversampling system clock, synchronises the asynchronous line and re-aligns to each start bit.
- Delivers each received byte with a one-cycle valid strobe and flags framing errors.

---
 rtl/uart_rx_8n1.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver with 2-flop input synchroniser and start-bit realignment.
// Optional build macro UART_RX_MAJORITY_EN: 2-of-3 majority vote per data/stop bit.
module uart_rx_8n1 #(
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_W        = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       busy,
    output logic       frame_err
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    state_t           state, state_n;
    logic             rx_m, rx_s;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       idx, idx_n;
    logic [7:0]       sh, sh_n;
    logic [7:0]       data_n;
    logic             valid_n, ferr_n;
    logic             bit_s;

    // Two-flop synchroniser; the line idles high so reset to 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= uart_rx;
            rx_s <= rx_m;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    localparam logic [CNT_W-1:0] M3 = CNT_W'(CLKS_PER_BIT - 3);
    localparam logic [CNT_W-1:0] M2 = CNT_W'(CLKS_PER_BIT - 2);
    logic maj0, maj1;

    // Capture the two early votes late in each data/stop bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            maj0 <= 1'b0;
            maj1 <= 1'b0;
        end else if (state == DATA || state == STOP) begin
            if (cnt == M3) maj0 <= rx_s;
            if (cnt == M2) maj1 <= rx_s;
        end
    end

    assign bit_s = (maj0 & maj1) | (maj0 & rx_s) | (maj1 & rx_s);
`else
    assign bit_s = rx_s;
`endif

    // FSM state, counters, shift register and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            sh        <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            idx       <= idx_n;
            sh        <= sh_n;
            data      <= data_n;
            valid     <= valid_n;
            frame_err <= ferr_n;
        end
    end

    // Next-state logic; counter clears on every state change.
    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        idx_n   = idx;
        sh_n    = sh;
        data_n  = data;
        valid_n = 1'b0;
        ferr_n  = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_n = '0;
                if (!rx_s) state_n = START;
            end
            START: begin
                if (cnt == HALF) begin
                    cnt_n = '0;
                    if (!rx_s) begin
                        state_n = DATA;
                        idx_n   = '0;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            DATA: begin
                if (cnt == LAST) begin
                    cnt_n = '0;
                    sh_n  = {bit_s, sh[7:1]};
                    if (idx == 3'd7) state_n = STOP;
                    else idx_n = idx + 3'd1;
                end
            end
            STOP: begin
                if (cnt == LAST) begin
                    cnt_n = '0;
                    if (bit_s) begin
                        data_n  = sh;
                        valid_n = 1'b1;
                        state_n = IDLE;
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                cnt_n = '0;
                if (rx_s) state_n = IDLE;
            end
            default: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule
